// File: rtl/xor_arb_pkg.sv
// Shared constants, output-state encoding and index helpers for the shared XOR arbiter.
package xor_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot_to_index(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the last winner, with wrap-around.
module rr_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic             any
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/xor_share_arbiter.sv
// One registered XOR unit shared by N_REQ requesters through a round-robin arbiter
// feeding a single-entry ready/valid output register.
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       ack,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id
);

    out_state_t        state, state_nx;
    logic [ID_W-1:0]   last;
    logic [N_REQ-1:0]  grant;
    logic              any;
    logic              slot_free;
    logic              issue;
    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  xor_sel;

    logic [N_REQ-1:0]  ack_p1;
    logic [WIDTH-1:0]  res_data_p1;
    logic [ID_W-1:0]   res_id_p1;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .last  (last),
        .grant (grant),
        .any   (any)
    );

    assign slot_free = (state == OUT_EMPTY) || res_ready;
    assign issue     = en && slot_free && any;
    assign win_id    = ID_W'(onehot_to_index(32'(grant)));

    // AND-OR select keyed by the one-hot grant avoids a variable part-select.
    always_comb begin
        xor_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                xor_sel = xor_sel | (op_a[i*WIDTH +: WIDTH] ^ op_b[i*WIDTH +: WIDTH]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            OUT_EMPTY: if (issue) state_nx = OUT_FULL;
            OUT_FULL: begin
                if (issue) begin
                    state_nx = OUT_FULL;
                end else if (res_ready) begin
                    state_nx = OUT_EMPTY;
                end
            end
            default:   state_nx = OUT_EMPTY;
        endcase
    end

    always_comb begin
        res_valid = (state == OUT_FULL);
    end

    // Stage p1: issued operation captured into the output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_p1      <= '0;
            res_data_p1 <= '0;
            res_id_p1   <= '0;
            last        <= ID_W'(N_REQ - 1);
        end else begin
            ack_p1 <= issue ? grant : '0;
            if (issue) begin
                res_data_p1 <= xor_sel;
                res_id_p1   <= win_id;
                last        <= win_id;
            end
        end
    end

    assign ack      = ack_p1;
    assign res_data = res_data_p1;
    assign res_id   = res_id_p1;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed and randomized checks of xor_share_arbiter against a cycle-level reference model.
module tb_xor_share_arbiter;
    import xor_arb_pkg::*;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = id_width(N_REQ);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       ack;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_data;
    logic [ID_W-1:0]        res_id;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    xor_share_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .ack       (ack),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    // Reference model: output slot as {valid,data,id}, pointer as a plain integer.
    logic [N_REQ-1:0] m_ack;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_id;
    int               m_last;

    function automatic int model_winner(input logic [N_REQ-1:0] r, input int lst);
        for (int k = 1; k <= N_REQ; k++) begin
            int j;
            j = (lst + k) % N_REQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] pair_xor(input int i);
        return op_a[i*WIDTH +: WIDTH] ^ op_b[i*WIDTH +: WIDTH];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ack   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= 0;
            m_last  <= N_REQ - 1;
        end else if (en && (!m_valid || res_ready) && model_winner(req, m_last) >= 0) begin
            m_ack   <= N_REQ'(1 << model_winner(req, m_last));
            m_valid <= 1'b1;
            m_data  <= pair_xor(model_winner(req, m_last));
            m_id    <= model_winner(req, m_last);
            m_last  <= model_winner(req, m_last);
        end else begin
            m_ack <= '0;
            if (m_valid && res_ready) m_valid <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; res_ready = 1'b1; req = 4'b1111;
        op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_cnt++; if (ack !== 4'b0000) $display("FAIL reset_ack cyc%0d got=%b want=0000", c, ack); else pass_cnt++;
            chk_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got=%b want=0", c, res_valid); else pass_cnt++;
        end
        chk_cnt++; if (res_data !== 8'h00 || res_id !== 2'd0) $display("FAIL reset_data_id got=%h/%0d want=00/0", res_data, res_id); else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++; if (ack !== 4'b0001) $display("FAIL reset_first_ack got=%b want=0001", ack); else pass_cnt++;
        chk_cnt++; if (res_id !== 2'd0) $display("FAIL reset_first_id got=%0d want=0", res_id); else pass_cnt++;
        chk_cnt++; if (res_data !== (8'h78 ^ 8'h0F)) $display("FAIL reset_first_data got=%h want=%h", res_data, 8'h78 ^ 8'h0F); else pass_cnt++;
    endtask

    task automatic test_single();
        req = 4'b0010;
        op_a[1*WIDTH +: WIDTH] = 8'hA5;
        op_b[1*WIDTH +: WIDTH] = 8'h0F;
        res_ready = 1'b1;
        tick();
        chk_cnt++; if (ack !== 4'b0010) $display("FAIL single_ack got=%b want=0010", ack); else pass_cnt++;
        chk_cnt++; if (res_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", res_valid); else pass_cnt++;
        chk_cnt++; if (res_data !== 8'hAA) $display("FAIL single_data got=%h want=aa", res_data); else pass_cnt++;
        chk_cnt++; if (res_id !== 2'd1) $display("FAIL single_id got=%0d want=1", res_id); else pass_cnt++;
        req = 4'b0000;
        tick();
        chk_cnt++; if (res_valid !== 1'b0 || ack !== 4'b0000) $display("FAIL single_drain got=%b/%b want=0/0000", res_valid, ack); else pass_cnt++;
        chk_cnt++; if (res_data !== 8'hAA || res_id !== 2'd1) $display("FAIL single_hold got=%h/%0d want=aa/1", res_data, res_id); else pass_cnt++;
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] exp_ack;
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0; en = 1'b1; res_ready = 1'b1; req = 4'b1111;
        op_a = {$urandom}; op_b = {$urandom};
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_ack = N_REQ'(1 << (k % 4));
            chk_cnt++; if (ack !== exp_ack) $display("FAIL fair_ack step%0d got=%b want=%b", k, ack, exp_ack); else pass_cnt++;
            chk_cnt++; if (res_id !== ID_W'(k % 4) || res_valid !== 1'b1) $display("FAIL fair_id step%0d got=%0d/%b want=%0d/1", k, res_id, res_valid, k % 4); else pass_cnt++;
            chk_cnt++; if (res_data !== pair_xor(k % 4)) $display("FAIL fair_data step%0d got=%h want=%h", k, res_data, pair_xor(k % 4)); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held;
        req = 4'b0100;
        tick();
        chk_cnt++; if (res_id !== 2'd2 || ack !== 4'b0100) $display("FAIL bp_setup got=%0d/%b want=2/0100", res_id, ack); else pass_cnt++;
        held = pair_xor(2);
        res_ready = 1'b0; req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_cnt++; if (res_id !== 2'd2 || res_data !== held) $display("FAIL bp_hold cyc%0d got=%0d/%h want=2/%h", c, res_id, res_data, held); else pass_cnt++;
            chk_cnt++; if (ack !== 4'b0000 || res_valid !== 1'b1) $display("FAIL bp_ack cyc%0d got=%b/%b want=0000/1", c, ack, res_valid); else pass_cnt++;
        end
        res_ready = 1'b1;
        tick();
        chk_cnt++; if (res_id !== 2'd3 || ack !== 4'b1000 || res_valid !== 1'b1) $display("FAIL bp_release got=%0d/%b/%b want=3/1000/1", res_id, ack, res_valid); else pass_cnt++;
        chk_cnt++; if (res_data !== pair_xor(3)) $display("FAIL bp_release_data got=%h want=%h", res_data, pair_xor(3)); else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_enable();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0; en = 1'b1; res_ready = 1'b1; req = 4'b0001;
        tick();
        chk_cnt++; if (ack !== 4'b0001) $display("FAIL en_setup got=%b want=0001", ack); else pass_cnt++;
        en = 1'b0; req = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_cnt++; if (ack !== 4'b0000 || res_valid !== 1'b0) $display("FAIL en_gate cyc%0d got=%b/%b want=0000/0", c, ack, res_valid); else pass_cnt++;
        end
        en = 1'b1;
        tick();
        chk_cnt++; if (ack !== 4'b0100 || res_id !== 2'd2) $display("FAIL en_resume got=%b/%0d want=0100/2", ack, res_id); else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b0001; res_ready = 1'b0; en = 1'b1;
        tick();
        req = '0;
        tick();
        chk_cnt++; if (res_valid !== 1'b1) $display("FAIL rmid_full got=%b want=1", res_valid); else pass_cnt++;
        rst = 1'b1;
        tick();
        chk_cnt++; if (res_valid !== 1'b0 || ack !== 4'b0000) $display("FAIL rmid_clear got=%b/%b want=0/0000", res_valid, ack); else pass_cnt++;
        rst = 1'b0; req = 4'b1010; res_ready = 1'b1;
        tick();
        chk_cnt++; if (ack !== 4'b0010 || res_id !== 2'd1) $display("FAIL rmid_rearb got=%b/%0d want=0010/1", ack, res_id); else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 99) < 60);
                    op_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    op_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if ($urandom_range(0, 99) < 5) begin
                    req[i] = 1'b0;
                end
            end
            en        = ($urandom_range(0, 99) < 85);
            res_ready = ($urandom_range(0, 99) < 70);
            rst       = ($urandom_range(0, 199) < 3);
            tick();
            chk_cnt++;
            if ({ack, res_valid, res_data, res_id} !== {m_ack, m_valid, m_data, ID_W'(m_id)})
                $display("FAIL rand cyc%0d got ack=%b v=%b d=%h id=%0d want ack=%b v=%b d=%h id=%0d",
                         c, ack, res_valid, res_data, res_id, m_ack, m_valid, m_data, m_id);
            else pass_cnt++;
            if (ack != '0) begin
                chk_cnt++;
                if (onehot_to_index(32'(ack)) != int'(res_id) || $countones(ack) != 1)
                    $display("FAIL rand_ack_id cyc%0d got ack=%b id=%0d want onehot at id", c, ack, res_id);
                else pass_cnt++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; op_a = '0; op_b = '0; res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
